// File: rtl/calc_controller.sv
// Sequencing FSM for the 8-bit four-function calculator: walks A / op / B entry,
// launches the AU with a watchdog, and drives the output unit and error code.
module calc_controller #(
   parameter int AU_TIMEOUT = 32
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       Enter,
   input  logic       ClearKey,
   input  logic [1:0] Op,
   input  logic       BZero,
   input  logic       AUDone,
   output logic       LoadA,
   output logic       LoadOp,
   output logic       LoadB,
   output logic       AUStart,
   output logic [1:0] OpSel,
   output logic       IUAU,
   output logic       LoadOU,
   output logic       ClearOU,
   output logic [1:0] Error,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_LDB  = 3'd3,
      S_CHK  = 3'd4,
      S_RUN  = 3'd5,
      S_SHOW = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   state_t     state, nxt;
   logic       enter_q, ck_q, rise;
   logic [7:0] cnt;

   assign rise  = Enter & ~enter_q;
   assign State = state;

   always_comb begin
      nxt = state;
      unique case (state)
         S_A:    if (rise) nxt = S_OP;
         S_OP:   if (rise) nxt = S_B;
         S_B:    if (rise) nxt = S_LDB;
         S_LDB:  nxt = S_CHK;
         S_CHK:  nxt = (OpSel == 2'b11 && BZero) ? S_ERR : S_RUN;
         S_RUN:  begin
            // completion beats the watchdog when both land in the same cycle
            if (AUDone)                               nxt = S_SHOW;
            else if (cnt == 8'(AU_TIMEOUT - 1))       nxt = S_ERR;
         end
         S_SHOW: if (rise) nxt = S_A;
         S_ERR:  if (rise) nxt = S_A;
         default: nxt = S_A;
      endcase
      if (ClearKey) nxt = S_A;
   end

   // Outputs are registered from the next state so they line up with State.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state   <= S_A;
         enter_q <= 1'b1;
         ck_q    <= 1'b0;
         cnt     <= 8'd0;
         LoadA   <= 1'b0;
         LoadOp  <= 1'b0;
         LoadB   <= 1'b0;
         AUStart <= 1'b0;
         OpSel   <= 2'b00;
         IUAU    <= 1'b0;
         LoadOU  <= 1'b0;
         ClearOU <= 1'b0;
         Error   <= 2'b00;
      end else begin
         state   <= nxt;
         enter_q <= Enter;
         ck_q    <= ClearKey;
         cnt     <= (state == S_RUN) ? cnt + 8'd1 : 8'd0;
         LoadA   <= (nxt == S_OP)  && (state != S_OP);
         LoadOp  <= (nxt == S_B)   && (state != S_B);
         LoadB   <= (nxt == S_LDB) && (state != S_LDB);
         AUStart <= (nxt == S_RUN) && (state != S_RUN);
         IUAU    <= (nxt == S_RUN) || (nxt == S_SHOW) || (nxt == S_ERR);
         LoadOU  <= (nxt == S_A) || (nxt == S_B) ||
                    ((nxt == S_SHOW) && (state != S_SHOW));
         // a held ClearKey pulses the output-unit clear only on its leading edge
         ClearOU <= (ClearKey & ~ck_q) ||
                    ((nxt == S_A) && ((state == S_SHOW) || (state == S_ERR)));
         if (ClearKey)
            OpSel <= 2'b00;
         else if (state == S_OP && rise)
            OpSel <= Op;
         if (ClearKey)
            Error <= 2'b00;
         else if (state == S_CHK && nxt == S_ERR)
            Error <= 2'b01;
         else if (state == S_RUN && nxt == S_ERR)
            Error <= 2'b10;
         else if (state == S_ERR && nxt == S_A)
            Error <= 2'b00;
      end
   end

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: directed scenarios with literal expectations, then
// random key/AU activity checked every cycle against a state/age reference model.
module tb_calc_controller;
   localparam int AU_T = 4;

   logic       CLK = 1'b0;
   logic       CLR, Enter, ClearKey, BZero, AUDone;
   logic [1:0] Op;
   logic       LoadA, LoadOp, LoadB, AUStart, IUAU, LoadOU, ClearOU;
   logic [1:0] OpSel, Error;
   logic [2:0] State;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   calc_controller #(.AU_TIMEOUT(AU_T)) dut (
      .CLK(CLK), .CLR(CLR), .Enter(Enter), .ClearKey(ClearKey), .Op(Op),
      .BZero(BZero), .AUDone(AUDone), .LoadA(LoadA), .LoadOp(LoadOp),
      .LoadB(LoadB), .AUStart(AUStart), .OpSel(OpSel), .IUAU(IUAU),
      .LoadOU(LoadOU), .ClearOU(ClearOU), .Error(Error), .State(State)
   );

   always #5 CLK = ~CLK;

   // Reference model: phase number plus cycles spent in that phase.
   logic [2:0] m_st, n_st;
   int         m_age, n_age;
   logic       m_eq, m_ckq, m_clrou, n_clrou, m_fresh, m_rise;
   logic [1:0] m_opsel, n_opsel, m_err, n_err;

   always_comb begin
      m_rise  = Enter && !m_eq;
      n_st    = m_st;
      n_opsel = m_opsel;
      n_err   = m_err;
      n_clrou = 1'b0;
      if (ClearKey) begin
         n_st = 3'd0; n_opsel = 2'd0; n_err = 2'd0; n_clrou = !m_ckq;
      end else begin
         case (m_st)
            3'd0: if (m_rise) n_st = 3'd1;
            3'd1: if (m_rise) begin n_st = 3'd2; n_opsel = Op; end
            3'd2: if (m_rise) n_st = 3'd3;
            3'd3: n_st = 3'd4;
            3'd4: if (m_opsel == 2'd3 && BZero) begin n_st = 3'd7; n_err = 2'd1; end
                  else n_st = 3'd5;
            3'd5: if (AUDone) n_st = 3'd6;
                  else if (m_age == AU_T - 1) begin n_st = 3'd7; n_err = 2'd2; end
            3'd6: if (m_rise) begin n_st = 3'd0; n_clrou = 1'b1; end
            default: if (m_rise) begin n_st = 3'd0; n_err = 2'd0; n_clrou = 1'b1; end
         endcase
      end
      n_age = (n_st == m_st) ? m_age + 1 : 0;
   end

   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         m_st <= 3'd0; m_age <= 0; m_eq <= 1'b1; m_ckq <= 1'b0;
         m_opsel <= 2'd0; m_err <= 2'd0; m_clrou <= 1'b0; m_fresh <= 1'b1;
      end else begin
         m_st <= n_st; m_age <= n_age; m_eq <= Enter; m_ckq <= ClearKey;
         m_opsel <= n_opsel; m_err <= n_err; m_clrou <= n_clrou; m_fresh <= 1'b0;
      end
   end

   function automatic logic [13:0] expv();
      logic la, lop, lb, ast, iu, lou, cou;
      la  = (m_st == 3'd1) && (m_age == 0);
      lop = (m_st == 3'd2) && (m_age == 0);
      lb  = (m_st == 3'd3) && (m_age == 0);
      ast = (m_st == 3'd5) && (m_age == 0);
      iu  = (m_st >= 3'd5);
      lou = (m_st == 3'd0) || (m_st == 3'd2) || ((m_st == 3'd6) && (m_age == 0));
      cou = m_clrou;
      if (m_fresh) {la, lop, lb, ast, iu, lou, cou} = 7'd0;
      return {la, lop, lb, ast, m_opsel, iu, lou, cou, m_err, m_st};
   endfunction

   wire [13:0] dutv = {LoadA, LoadOp, LoadB, AUStart, OpSel, IUAU, LoadOU,
                       ClearOU, Error, State};

   always @(negedge CLK) begin
      if (chk_en) begin
         vectors++;
         if (dutv !== expv()) begin
            miscompares++;
            $display("FAIL outputs t=%0t got %h want %h", $time, dutv, expv());
         end
      end
   end

   task automatic chk(input string nm, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press();
      Enter = 1'b1;
      cyc(1);
      Enter = 1'b0;
   endtask

   // From S_A: walk to the AUStart cycle with the given op.
   task automatic to_run(input logic [1:0] op);
      press(); cyc(2);
      Op = op; press(); cyc(2);
      press(); cyc(2);
   endtask

   int pulses;

   initial begin
      CLR = 1'b1; Enter = 1'b0; ClearKey = 1'b0; Op = 2'd0; BZero = 1'b0; AUDone = 1'b0;
      cyc(2);
      chk_en = 1'b1;
      chk("rst_state", int'(State), 0);
      chk("rst_loadou", int'(LoadOU), 0);
      chk("rst_opsel", int'(OpSel), 0);
      CLR = 1'b0;
      cyc(1);
      chk("sa_loadou", int'(LoadOU), 1);
      cyc(2);

      // add path
      Op = 2'd0; press();
      chk("add_loada", int'(LoadA), 1);
      chk("add_st1", int'(State), 1);
      cyc(1);
      chk("add_op_hold", int'(LoadOU), 0);
      cyc(1);
      press();
      chk("add_loadop", int'(LoadOp), 1);
      cyc(2);
      press();
      chk("add_loadb", int'(LoadB), 1);
      cyc(1); chk("add_chk", int'(State), 4);
      cyc(1); chk("add_austart", int'(AUStart), 1);
      cyc(1); AUDone = 1'b1;
      cyc(1); AUDone = 1'b0;
      chk("add_show_ld", int'({LoadOU, IUAU}), 3);
      chk("add_show_st", int'(State), 6);
      cyc(3);
      chk("add_show_hold", int'(LoadOU), 0);
      chk("add_err", int'(Error), 0);
      press();
      chk("add_clrou", int'(ClearOU), 1);
      cyc(2);

      // divide by zero
      press(); cyc(2);
      Op = 2'd3; press();
      chk("dz_opsel", int'(OpSel), 3);
      cyc(2);
      BZero = 1'b1; press(); cyc(2);
      chk("dz_state", int'(State), 7);
      chk("dz_error", int'(Error), 1);
      chk("dz_iuau_nostart", int'({IUAU, AUStart}), 2);
      cyc(2);
      press();
      chk("dz_back", int'({State, ClearOU}), 1);
      chk("dz_errclr", int'(Error), 0);
      BZero = 1'b0; cyc(2);

      // timeout
      to_run(2'd2);
      chk("to_start", int'(AUStart), 1);
      cyc(3); chk("to_still_run", int'(State), 5);
      cyc(1); chk("to_err", int'({State, Error}), (7 << 2) | 2);
      cyc(1); press(); chk("to_back", int'(State), 0);
      cyc(2);

      // done on the final watchdog count wins
      to_run(2'd2);
      cyc(3); AUDone = 1'b1;
      cyc(1); AUDone = 1'b0;
      chk("tie_show", int'({State, LoadOU, Error}), (6 << 3) | (1 << 2));
      cyc(1); press(); cyc(2);

      // ClearKey together with an Enter edge during S_RUN
      to_run(2'd1);
      cyc(1); ClearKey = 1'b1; Enter = 1'b1;
      cyc(1);
      chk("ck_state", int'(State), 0);
      chk("ck_clrou", int'(ClearOU), 1);
      chk("ck_opsel", int'(OpSel), 0);
      chk("ck_iuau", int'(IUAU), 0);
      cyc(1); chk("ck_once", int'(ClearOU), 0);
      Enter = 1'b0; cyc(1);
      chk("ck_hold_st", int'(State), 0);
      ClearKey = 1'b0; cyc(2);

      // Enter held through reset release
      Enter = 1'b1; CLR = 1'b1; cyc(2);
      CLR = 1'b0;
      pulses = 0;
      repeat (4) begin cyc(1); pulses += int'(LoadA); end
      chk("held_noload", pulses, 0);
      Enter = 1'b0; cyc(1);
      press(); pulses = int'(LoadA);
      repeat (3) begin cyc(1); pulses += int'(LoadA); end
      chk("held_one_loada", pulses, 1);

      // asynchronous reset in the middle of S_RUN
      press(); cyc(2); press(); cyc(2);
      chk("ar_run", int'(State), 5);
      @(posedge CLK); #2 CLR = 1'b1;
      #1;
      chk("ar_zero", int'(dutv), 0);
      @(negedge CLK); CLR = 1'b0;
      cyc(1);
      chk("ar_release", int'({State, LoadA, ClearOU, LoadOU}), 1);

      // random activity
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (CLR) CLR = 1'b0;
         else if ($urandom_range(0, 399) == 0) CLR = 1'b1;
         if ($urandom_range(0, 2) == 0) Enter = ~Enter;
         if (ClearKey) ClearKey = ($urandom_range(0, 2) != 0);
         else ClearKey = ($urandom_range(0, 49) == 0);
         Op     = 2'($urandom_range(0, 3));
         BZero  = ($urandom_range(0, 1) == 1);
         AUDone = ($urandom_range(0, 5) == 0);
      end
      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
